// File: rtl/display_scan_mux_pkg.sv
// Shared constants and helpers for the four-digit scanned hex display.
package display_scan_mux_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIBBLE_W = 4;

  // Digit-enable patterns (active low): digit 0 lit, and everything dark.
  localparam logic [DIGITS-1:0] AN_RESET = 4'b1110;
  localparam logic [DIGITS-1:0] AN_OFF   = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // One-cold digit enable for the selected slot.
  function automatic logic [DIGITS-1:0] an_decode(input digit_idx_t idx);
    logic [DIGITS-1:0] an;
    an      = AN_OFF;
    an[idx] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_tick_gen.sv
// Prescaler for the display scan: counts 0..PRESCALE-1 and flags the wrap
// cycle with a single-cycle TICK decoded straight from the count.
module scan_tick_gen
  import display_scan_mux_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic TICK
);

  localparam int unsigned    CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // PRESCALE=1 keeps cnt at 0, so TICK is high every cycle.
  assign TICK = (cnt == LAST);

  // Free-running slot counter; reset restarts a full period.
  always_ff @(posedge CLK) begin
    if (!RST_N)    cnt <= '0;
    else if (TICK) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit multiplexed hex display driver. A loaded 16-bit value is shown
// one nibble at a time on BIN, with the matching active-low enable on AN.
// Optional feature: define DISPLAY_SCAN_MUX_LZ_BLANK_EN to blank leading
// zero digits (digit 0 is always lit).
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         LOAD,
  input  logic [DIGITS*NIBBLE_W-1:0]   VALUE,
  output logic [NIBBLE_W-1:0]          BIN,
  output logic [DIGITS-1:0]            AN,
  output logic                         TICK
);

  logic [DIGITS*NIBBLE_W-1:0] held;
  digit_idx_t                 idx;
  logic                       blank;

  scan_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .TICK (TICK)
  );

  // Display value capture; loading never disturbs the scan position.
  always_ff @(posedge CLK) begin
    if (!RST_N)    held <= '0;
    else if (LOAD) held <= VALUE;
  end

  // Digit index advances once per prescaler wrap.
  always_ff @(posedge CLK) begin
    if (!RST_N)    idx <= '0;
    else if (TICK) idx <= idx + 1'b1;
  end

  // Nibble select driven from registers only.
  always_comb begin
    BIN = held[{idx, 2'b00} +: NIBBLE_W];
  end

`ifdef DISPLAY_SCAN_MUX_LZ_BLANK_EN
  // Slot k goes dark when digits k..3 are all zero.
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (held[15:4]  == '0);
      2'd2:    blank = (held[15:8]  == '0);
      2'd3:    blank = (held[15:12] == '0);
      default: blank = 1'b0;
    endcase
  end
`else
  // No blanking in this build.
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Active-low digit enable, at most one bit low.
  always_comb begin
    AN = blank ? AN_OFF : an_decode(idx);
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: one instance at PRESCALE=4 and one at
// PRESCALE=1 share clock, reset and load inputs.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  bin4, an4, bin1, an1;
  logic        tick4, tick1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  display_scan_mux #(.PRESCALE(4)) u4 (
    .CLK(clk), .RST_N(rst_n), .LOAD(load), .VALUE(value),
    .BIN(bin4), .AN(an4), .TICK(tick4)
  );

  display_scan_mux #(.PRESCALE(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .LOAD(load), .VALUE(value),
    .BIN(bin1), .AN(an1), .TICK(tick1)
  );

`ifdef DISPLAY_SCAN_MUX_LZ_BLANK_EN
  localparam logic [3:0] AN_S1 = 4'b1111;
  localparam logic [3:0] AN_S2 = 4'b1111;
  localparam logic [3:0] AN_S3 = 4'b1111;
`else
  localparam logic [3:0] AN_S1 = 4'b1101;
  localparam logic [3:0] AN_S2 = 4'b1011;
  localparam logic [3:0] AN_S3 = 4'b0111;
`endif

  // Expected PRESCALE=4 outputs after release edges 1..25 (VALUE 1A3F loaded at edge 2).
  logic [3:0] a_bin [25] = '{4'h0, 4'hF, 4'hF, 4'h3, 4'h3, 4'h3, 4'h3, 4'hA, 4'hA, 4'hA,
                             4'hA, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h3,
                             4'h3, 4'h3, 4'h3, 4'hA, 4'hA};
  logic [3:0] a_an  [25] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD, 4'hB, 4'hB, 4'hB,
                             4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE, 4'hE, 4'hE, 4'hE, 4'hD,
                             4'hD, 4'hD, 4'hD, 4'hB, 4'hB};
  logic       a_tick[25] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] d_bin [4]  = '{4'h2, 4'h3, 4'h4, 4'h1};
  logic [3:0] d_an  [4]  = '{4'hD, 4'hB, 4'h7, 4'hE};

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    value = 16'h0000;
    step(2);
    check("rst_bin4",  bin4, 4'h0);
    check("rst_an4",   an4,  4'b1110);
    check("rst_tick4", 4'(tick4), 4'h0);
    check("rst_an1",   an1,  4'b1110);
    check("rst_tick1", 4'(tick1), 4'h1);
    rst_n = 1'b1;

    // Reset release cadence and 1A3F scan.
    for (int c = 0; c < 25; c++) begin
      step(1);
      check($sformatf("scan_bin_e%0d", c + 1), bin4, a_bin[c]);
      check($sformatf("scan_an_e%0d", c + 1), an4, a_an[c]);
      check($sformatf("scan_tick_e%0d", c + 1), 4'(tick4), 4'(a_tick[c]));
      load  = (c == 0);
      value = (c == 0) ? 16'h1A3F : 16'h0000;
    end

    // Single-cycle reset while on digit 2.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mid_rst_bin4",  bin4, 4'h0);
    check("mid_rst_an4",   an4,  4'b1110);
    check("mid_rst_tick4", 4'(tick4), 4'h0);
    check("mid_rst_bin1",  bin1, 4'h0);
    step(1);
    check("post_rst_tick_d1", 4'(tick4), 4'h0);
    step(1);
    check("post_rst_tick_d2", 4'(tick4), 4'h0);
    step(1);
    check("post_rst_tick_d3", 4'(tick4), 4'h1);
    check("post_rst_bin_d3",  bin4, 4'h0);

    // BEEF load coincides with the edge moving digit 0 -> 1.
    load  = 1'b1;
    value = 16'hBEEF;
    step(1);
    load  = 1'b0;
    check("coinc_bin",  bin4, 4'hE);
    check("coinc_an",   an4,  4'b1101);
    check("coinc_tick", 4'(tick4), 4'h0);
    step(3);
    check("coinc_cadence_tick", 4'(tick4), 4'h1);
    step(1);
    check("beef_d2_bin", bin4, 4'hE);
    check("beef_d2_an",  an4,  4'b1011);
    step(4);
    check("beef_d3_bin", bin4, 4'hB);
    check("beef_d3_an",  an4,  4'b0111);

    // PRESCALE=1 instance with 4321: one digit per clock.
    load  = 1'b1;
    value = 16'h4321;
    step(1);
    load  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1);
      check($sformatf("p1_bin_%0d", k), bin1, d_bin[k]);
      check($sformatf("p1_an_%0d", k), an1, d_an[k]);
      check($sformatf("p1_tick_%0d", k), 4'(tick1), 4'h1);
    end

    // Leading-zero handling with 0050, then 0000.
    load  = 1'b1;
    value = 16'h0050;
    step(1);
    load  = 1'b0;
    check("lz50_s0_bin", bin4, 4'h0);
    check("lz50_s0_an",  an4,  4'b1110);
    step(3);
    check("lz50_s1_bin", bin4, 4'h5);
    check("lz50_s1_an",  an4,  4'b1101);
    step(4);
    check("lz50_s2_an",  an4,  AN_S2);
    step(4);
    check("lz50_s3_an",  an4,  AN_S3);
    load  = 1'b1;
    value = 16'h0000;
    step(1);
    load  = 1'b0;
    check("lz0_s3_an",  an4,  AN_S3);
    check("lz0_s3_bin", bin4, 4'h0);
    step(3);
    check("lz0_s0_an",  an4,  4'b1110);
    check("lz0_s0_bin", bin4, 4'h0);
    step(4);
    check("lz0_s1_an",  an4,  AN_S1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clock cycles per digit slot; legal range 1..2^20.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1, synchronous active-low reset sampled on the rising edge of CLK.
REQ-004 SHALL have port LOAD, input, 1, a one-cycle strobe that captures VALUE.
REQ-005 SHALL have port VALUE, input, 16, four hex digits; [3:0] is digit 0 (least significant).
REQ-006 SHALL have port BIN, output, 4, the nibble of the currently scanned digit, fed to the seven-segment decoder.
REQ-007 SHALL have port AN, output, 4, active-low digit enables; at most one bit low at any time.
REQ-008 SHALL have port TICK, output, 1, high for exactly one cycle when the scan advances.

Function
REQ-009 SHALL hold a 16-bit register HELD; on a rising edge with LOAD=1, HELD <= VALUE; otherwise HELD is unchanged.
REQ-010 SHALL count with prescaler CNT 0..PRESCALE-1; at PRESCALE-1 it wraps to 0 and TICK=1 for that cycle (combinational from CNT).
REQ-011 SHALL hold a 2-bit digit index IDX; on a rising edge with TICK=1, IDX <= IDX+1 mod 4 (3 wraps to 0).
REQ-012 SHALL drive BIN = HELD[4*IDX+3 : 4*IDX] and AN = all ones except bit IDX low, both decoded from registers only (no input-to-output path).
REQ-013 SHALL give zero latency from register to output: a LOAD at edge n is visible on BIN at edge n when IDX selects the changed digit.
REQ-014 SHALL leave CNT and IDX undisturbed by LOAD; loading never restarts the scan.
REQ-015 SHALL apply both updates in the same cycle when LOAD and the TICK edge coincide: BIN shows the new HELD at the new IDX.
REQ-016 SHALL give TICK=1 every cycle with PRESCALE=1, so IDX advances every clock.

Reset
REQ-017 SHALL, on a rising edge with RST_N=0, set CNT=0, IDX=0 and HELD=16'h0000, giving BIN=4'h0, AN=4'b1110, TICK=0 (TICK=1 if PRESCALE=1).
REQ-018 SHALL give reset priority over LOAD; a reset mid-scan abandons the current slot and restarts from digit 0 with a full PRESCALE period.

Configuration
REQ-019 SHALL, with macro DISPLAY_SCAN_MUX_LZ_BLANK_EN defined, force AN to 4'b1111 during slot k (k=1..3) when HELD digits k..3 are all zero; digit 0 is never blanked and IDX/TICK timing is unchanged.
REQ-020 SHALL, without DISPLAY_SCAN_MUX_LZ_BLANK_EN, never blank a digit; AN follows REQ-012 exactly.

Structure
REQ-021 SHALL place in the shared calculator package: digit count constant (4), nibble width constant (4), and the AN reset/all-off constants (4'b1110, 4'b1111).
REQ-022 SHALL implement the prescaler as one sub-module, scan_tick_gen (parameter PRESCALE; ports CLK, RST_N, TICK); IDX, HELD and output decode stay in the top level.

Verification
REQ-023 PRESCALE=4, RST_N=0 for 2 cycles then 1 -> BIN=0, AN=1110; TICK first high 3 cycles after release, then every 4th cycle.
REQ-024 PRESCALE=4, LOAD with VALUE=16'h1A3F -> BIN sequence F,3,A,1,F with AN 1110,1101,1011,0111,1110, each held 4 cycles.
REQ-025 PRESCALE=4, LOAD VALUE=16'hBEEF on the same edge as TICK moving IDX 0->1 -> BIN=E, AN=1101 that cycle; CNT/IDX cadence unchanged.
REQ-026 PRESCALE=1, VALUE=16'h4321 -> BIN cycles 1,2,3,4 every clock, TICK constant 1.
REQ-027 PRESCALE=4, RST_N low for one cycle while IDX=2 -> next cycle BIN=0, AN=1110, HELD=0, next TICK 4 cycles later.
REQ-028 With DISPLAY_SCAN_MUX_LZ_BLANK_EN, VALUE=16'h0050 -> AN=1110 (0), 1101 (5), 1111, 1111; VALUE=16'h0000 -> only digit 0 lit showing 0.
